// File: rtl/frame_window_fetcher.sv
// frame_window_fetcher: read-side sequencer that fetches a 3x3 pixel neighbourhood
// from frame_buffer and presents it to the edge stage with a valid/ready handshake.
module frame_window_fetcher #(
  parameter int unsigned P_COLUMNS     = 640,
  parameter int unsigned P_ROWS        = 3,
  parameter int unsigned P_PIXEL_DEPTH = 24
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_ENABLE,
  input  logic                           I_START,
  input  logic [$clog2(P_COLUMNS)-1:0]   I_CENTER_COL,
  input  logic [$clog2(P_ROWS)-1:0]      I_CENTER_ROW,
  input  logic                           I_READY,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  output logic [$clog2(P_COLUMNS)-1:0]   O_PIXEL_COL,
  output logic [$clog2(P_ROWS)-1:0]      O_PIXEL_ROW,
  output logic                           O_READ_ENABLE,
  output logic                           O_WRITE_ENABLE,
  output logic [9*P_PIXEL_DEPTH-1:0]     O_WINDOW,
  output logic                           O_VALID,
  output logic                           O_BUSY
);

  localparam int unsigned ColWidth = $clog2(P_COLUMNS);
  localparam int unsigned RowWidth = $clog2(P_ROWS);
  localparam logic [ColWidth-1:0] ColMax  = ColWidth'(P_COLUMNS - 1);
  localparam logic [RowWidth-1:0] RowMax  = RowWidth'(P_ROWS - 1);
  localparam logic [3:0]          LastIdx = 4'd8;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StValid} state_e;

  state_e                               state_q, state_d;
  logic [3:0]                           idx_q, idx_d;
  logic [ColWidth-1:0]                  center_col_q, center_col_d;
  logic [RowWidth-1:0]                  center_row_q, center_row_d;
  logic [ColWidth-1:0]                  addr_col_q, addr_col_d;
  logic [RowWidth-1:0]                  addr_row_q, addr_row_d;
  logic                                 rd_en_q, rd_en_d;
  // Stage-1 tag: which element the frame_buffer is reading this cycle.
  logic                                 s1_valid_q, s1_valid_d;
  logic [3:0]                           s1_idx_q, s1_idx_d;
  logic [8:0][P_PIXEL_DEPTH-1:0]        window_q, window_d;
  logic                                 valid_q, valid_d;
  logic                                 busy_q, busy_d;

  // Row offset (0/1/2 meaning -1/0/+1) of window element k.
  function automatic logic [1:0] row_off(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: row_off = 2'd0;
      4'd3, 4'd4, 4'd5: row_off = 2'd1;
      default:          row_off = 2'd2;
    endcase
  endfunction

  // Column offset (0/1/2 meaning -1/0/+1) of window element k.
  function automatic logic [1:0] col_off(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: col_off = 2'd0;
      4'd1, 4'd4, 4'd7: col_off = 2'd1;
      default:          col_off = 2'd2;
    endcase
  endfunction

  // Neighbour column with edge replication.
  function automatic logic [ColWidth-1:0] nb_col(input logic [ColWidth-1:0] c,
                                                 input logic [1:0] off);
    if (off == 2'd0)      nb_col = (c == '0) ? c : c - ColWidth'(1);
    else if (off == 2'd2) nb_col = (c == ColMax) ? c : c + ColWidth'(1);
    else                  nb_col = c;
  endfunction

  // Neighbour row with edge replication.
  function automatic logic [RowWidth-1:0] nb_row(input logic [RowWidth-1:0] r,
                                                 input logic [1:0] off);
    if (off == 2'd0)      nb_row = (r == '0) ? r : r - RowWidth'(1);
    else if (off == 2'd2) nb_row = (r == RowMax) ? r : r + RowWidth'(1);
    else                  nb_row = r;
  endfunction

  // Next-state: sequencing, address generation and pixel capture; all hold when disabled.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    center_col_d = center_col_q;
    center_row_d = center_row_q;
    addr_col_d   = addr_col_q;
    addr_row_d   = addr_row_q;
    rd_en_d      = rd_en_q;
    s1_valid_d   = s1_valid_q;
    s1_idx_d     = s1_idx_q;
    window_d     = window_q;
    if (I_ENABLE) begin
      // frame_buffer output lags the strobe by one edge; capture one edge after that.
      s1_valid_d = rd_en_q;
      s1_idx_d   = idx_q;
      if (s1_valid_q) window_d[s1_idx_q] = I_PIXEL;
      rd_en_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (I_START) begin
            state_d      = StFetch;
            idx_d        = 4'd0;
            center_col_d = (I_CENTER_COL > ColMax) ? ColMax : I_CENTER_COL;
            center_row_d = (I_CENTER_ROW > RowMax) ? RowMax : I_CENTER_ROW;
            rd_en_d      = 1'b1;
          end
        end
        StFetch: begin
          if (idx_q == LastIdx) begin
            state_d = StDrain;
          end else begin
            idx_d   = idx_q + 4'd1;
            rd_en_d = 1'b1;
          end
        end
        StDrain: state_d = StValid;
        StValid: if (I_READY) state_d = StIdle;
        default: state_d = StIdle;
      endcase
      // Addresses are registered, so present element idx_d together with the strobe.
      if (rd_en_d) begin
        addr_col_d = nb_col(center_col_d, col_off(idx_d));
        addr_row_d = nb_row(center_row_d, row_off(idx_d));
      end
    end
    valid_d = (state_d == StValid);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      center_col_q <= '0;
      center_row_q <= '0;
      addr_col_q   <= '0;
      addr_row_q   <= '0;
      rd_en_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= 4'd0;
      window_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      center_col_q <= center_col_d;
      center_row_q <= center_row_d;
      addr_col_q   <= addr_col_d;
      addr_row_q   <= addr_row_d;
      rd_en_q      <= rd_en_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      window_q     <= window_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign O_PIXEL_COL    = addr_col_q;
  assign O_PIXEL_ROW    = addr_row_q;
  assign O_READ_ENABLE  = rd_en_q;
  assign O_WRITE_ENABLE = 1'b0;
  assign O_WINDOW       = window_q;
  assign O_VALID        = valid_q;
  assign O_BUSY         = busy_q;

endmodule

// File: tb/tb_frame_window_fetcher.sv
// Directed self-checking bench for frame_window_fetcher with a behavioural frame_buffer.
module tb_frame_window_fetcher;

  localparam int Cols  = 640;
  localparam int Rows  = 3;
  localparam int Depth = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 start;
  logic [9:0]           ccol;
  logic [1:0]           crow;
  logic                 ready;
  logic [Depth-1:0]     fb_pixel;
  logic [9:0]           pcol;
  logic [1:0]           prow;
  logic                 rd_en;
  logic                 wr_en;
  logic [9*Depth-1:0]   window;
  logic                 valid;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  frame_window_fetcher #(
    .P_COLUMNS    (Cols),
    .P_ROWS       (Rows),
    .P_PIXEL_DEPTH(Depth)
  ) dut (
    .I_CLK         (clk),
    .I_RESET       (rst),
    .I_ENABLE      (en),
    .I_START       (start),
    .I_CENTER_COL  (ccol),
    .I_CENTER_ROW  (crow),
    .I_READY       (ready),
    .I_PIXEL       (fb_pixel),
    .O_PIXEL_COL   (pcol),
    .O_PIXEL_ROW   (prow),
    .O_READ_ENABLE (rd_en),
    .O_WRITE_ENABLE(wr_en),
    .O_WINDOW      (window),
    .O_VALID       (valid),
    .O_BUSY        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural frame_buffer: 1-cycle registered read, pixel(r,c) = {r at bit 16, c at bit 0}.
  always @(posedge clk or posedge rst) begin
    if (rst) fb_pixel <= '0;
    else if (en && rd_en && !wr_en) fb_pixel <= {6'd0, prow, 6'd0, pcol};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int exp_col(input int c, input int k);
    return clampi(clampi(c, Cols - 1) + (k % 3) - 1, Cols - 1);
  endfunction

  function automatic int exp_row(input int r, input int k);
    return clampi(clampi(r, Rows - 1) + (k / 3) - 1, Rows - 1);
  endfunction

  // Start a fetch, check each read address, optionally stall at element stall_k.
  task automatic do_fetch(input int c, input int r, input int stall_k, input int stall_n,
                          output int lat);
    ccol  = 10'(c);
    crow  = 2'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("addr_col_k%0d", k), pcol, exp_col(c, k));
      chk($sformatf("addr_row_k%0d", k), prow, exp_row(r, k));
      chk("rd_en_fetch", rd_en, 1'b1);
      chk("busy_fetch", busy, 1'b1);
      if (k == stall_k) begin
        en = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          lat++;
          chk("stall_col", pcol, exp_col(c, k));
          chk("stall_row", prow, exp_row(r, k));
          chk("stall_valid", valid, 1'b0);
        end
        en = 1'b1;
      end
      tick();
      lat++;
    end
    chk("rd_en_drain", rd_en, 1'b0);
    chk("valid_drain", valid, 1'b0);
    while (!valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_window(input int c, input int r);
    for (int k = 0; k < 9; k++)
      chk($sformatf("window_k%0d", k), window[k*Depth +: Depth],
          exp_row(r, k) * 65536 + exp_col(c, k));
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("valid_after_ready", valid, 1'b0);
    chk("busy_after_ready", busy, 1'b0);
  endtask

  int                 lat;
  logic [9*Depth-1:0] saved;

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    ccol  = '0;
    crow  = '0;
    ready = 1'b0;
    #12;
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rd_en", rd_en, 1'b0);
    chk("reset_window", window, '0);
    chk("reset_col", pcol, '0);
    chk("reset_row", prow, '0);
    rst = 1'b0;
    tick();
    chk("write_enable", wr_en, 1'b0);

    // Interior fetch
    do_fetch(100, 1, -1, 0, lat);
    chk("latency_interior", lat, 10);
    chk("busy_valid", busy, 1'b1);
    check_window(100, 1);
    accept();

    // Left/top border
    do_fetch(0, 0, -1, 0, lat);
    chk("latency_corner", lat, 10);
    chk("corner_elem0", window[0 +: Depth], 24'h000000);
    chk("corner_elem8", window[8*Depth +: Depth], 24'h010001);
    check_window(0, 0);
    accept();

    // Right border, then overrange column and row with identical window
    do_fetch(639, 2, -1, 0, lat);
    check_window(639, 2);
    saved = window;
    accept();
    do_fetch(700, 3, -1, 0, lat);
    chk("latency_overrange", lat, 10);
    chk("overrange_same_window", window, saved);
    accept();

    // Backpressure: window holds, a start pulse is ignored
    do_fetch(5, 1, -1, 0, lat);
    check_window(5, 1);
    saved = window;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        ccol  = 10'd300;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("bp_valid", valid, 1'b1);
      chk("bp_window", window, saved);
    end
    start = 1'b0;
    accept();
    tick();
    chk("no_queued_start", busy, 1'b0);
    do_fetch(320, 2, -1, 0, lat);
    chk("latency_after_bp", lat, 10);
    check_window(320, 2);
    accept();

    // Enable stall at element 4
    do_fetch(200, 1, 4, 5, lat);
    chk("latency_stall", lat, 15);
    check_window(200, 1);
    accept();

    // Asynchronous reset at element 6
    ccol  = 10'd50;
    crow  = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_reset_col", pcol, exp_col(50, 6));
    rst = 1'b1;
    #1;
    chk("areset_valid", valid, 1'b0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_rd_en", rd_en, 1'b0);
    chk("areset_window", window, '0);
    chk("areset_col", pcol, '0);
    chk("areset_row", prow, '0);
    #1;
    rst = 1'b0;
    repeat (15) tick();
    chk("post_reset_valid", valid, 1'b0);
    chk("post_reset_busy", busy, 1'b0);
    do_fetch(50, 1, -1, 0, lat);
    chk("latency_post_reset", lat, 10);
    check_window(50, 1);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_window_fetcher.md
Name: frame_window_fetcher

Overview:
Read-side sequencer for frame_buffer. On a start request it issues the nine row/column read addresses of a 3x3 neighbourhood around a centre pixel and captures the frame_buffer's registered pixel output. It presents the assembled window to the Sobel/edge stage with a valid/ready handshake. It never writes the buffer and shares I_ENABLE with it.

Parameters:
P_COLUMNS, 640, columns in the frame; column address width is clog2(P_COLUMNS).
P_ROWS, 3, rows held in the frame buffer; row address width is clog2(P_ROWS).
P_PIXEL_DEPTH, 24, bits per pixel.

Ports:
I_CLK  input  1  clock
I_RESET  input  1  reset, asynchronous, active-high
I_ENABLE  input  1  global enable; when low, all state holds (same net as frame_buffer I_ENABLE)
I_START  input  1  request a window fetch; sampled only in IDLE
I_CENTER_COL  input  clog2(P_COLUMNS)  centre column, latched on accepted start
I_CENTER_ROW  input  clog2(P_ROWS)  centre row, latched on accepted start
I_READY  input  1  consumer accepts the window
I_PIXEL  input  P_PIXEL_DEPTH  frame_buffer O_PIXEL
O_PIXEL_COL  output  clog2(P_COLUMNS)  read column to frame_buffer
O_PIXEL_ROW  output  clog2(P_ROWS)  read row to frame_buffer
O_READ_ENABLE  output  1  read strobe to frame_buffer
O_WRITE_ENABLE  output  1  constant 0
O_WINDOW  output  9*P_PIXEL_DEPTH  window; element k at bits [(k+1)*D-1 : k*D], k = 3*dr + dc, dr/dc in {0,1,2} = offset -1/0/+1
O_VALID  output  1  window valid, held until accepted
O_BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state IDLE, index 0, all outputs 0, latched centre 0.
- I_ENABLE low: state, index, address outputs, capture registers and O_VALID all hold. I_START and I_READY are ignored.
- All outputs are registered.
- States: IDLE -> FETCH -> DRAIN -> VALID -> IDLE.
- IDLE: I_START=1 at an edge latches the centre, clears index to 0 and enters FETCH. I_START in any other state is ignored, with no queuing.
- Clamping: centre col >= P_COLUMNS clamps to P_COLUMNS-1, and centre row >= P_ROWS clamps to P_ROWS-1. Neighbour col = clamp(c+dc-1, 0, P_COLUMNS-1); neighbour row is clamped the same way (edge replicate).
- FETCH, index k = 0..8: O_READ_ENABLE=1 and O_PIXEL_ROW/COL address element k. The index increments every enabled edge. After k=8 the state goes to DRAIN.
- DRAIN: O_READ_ENABLE=0 for one cycle, then the state goes to VALID.
- Capture: element k is taken from I_PIXEL at the second enabled edge after the edge that presented address k (frame_buffer has 1-cycle registered read). Element 8 is captured on the DRAIN->VALID edge.
- Latency: O_VALID rises 10 enabled edges after the start-accepting edge.
- VALID: O_VALID=1 and O_WINDOW stable. I_READY=1 at an edge returns the state to IDLE and drops O_VALID. A new start can be accepted at the next edge, not in the same cycle.
- O_PIXEL_COL/ROW hold their last value outside FETCH. O_WINDOW holds until overwritten by the next fetch's captures.
- O_WRITE_ENABLE is 0 at all times, so frame_buffer read-enable gating always passes.
- Reset mid-fetch: immediate IDLE, O_WINDOW zeroed, no O_VALID.

Test Plan:
- Interior fetch. Behavioural frame_buffer, pixel(r,c)=r*65536+c, start col=100 row=1 -> read addresses (0,99),(0,100),(0,101),(1,99)...(2,101) on 9 consecutive cycles. O_VALID rises 10 cycles after start; O_WINDOW[k]=pixel matching address k; O_BUSY high throughout.
- Left/top border. Start col=0 row=0 -> column addresses 0,0,1 and row addresses 0,0,1; window element 0 = pixel(0,0), element 8 = pixel(1,1).
- Right border/overrange. Start col=639 -> columns 638,639,639; start col=700 -> treated as 639, with identical window.
- Backpressure. Hold I_READY=0 for 20 cycles after O_VALID -> window stable and an I_START pulse is ignored. I_READY=1 -> O_VALID low next cycle; start two cycles later succeeds.
- Enable stall. Drop I_ENABLE for 5 cycles at FETCH index 4 -> address outputs and index frozen; the window is still correct and latency stretches to 15 cycles.
- Async reset. Assert I_RESET at FETCH index 6 -> all outputs 0 immediately; after release, no O_VALID until a fresh I_START.
